// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory bus: icache and dcache request ports plus the single RAM port.
// The arbiter uses the slave view; the caches/RAM side uses the master view.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter: grants the RAM port to dcache (priority, locked across
// multi-word sequences) or icache, and raises a sticky err on RAM error or stall timeout.
module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    cache_mem_arbiter_if.slave   bus,
    output logic                 err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               access;
    logic               dreq;
    logic               ram_ren, ram_wen;

    assign access = (bus.ramstate == RAM_ACCESS);
    assign dreq   = bus.dREN | bus.dWEN;

    // Output decode from the registered grant
    always_comb begin
        ram_ren      = 1'b0;
        ram_wen      = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        case (state_q)
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                ram_wen      = bus.dWEN;
                ram_ren      = bus.dREN & ~bus.dWEN;
                bus.dwait    = ~access;
                bus.dload    = bus.ramload;
            end
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                ram_ren     = bus.iREN;
                bus.iwait   = ~access;
                bus.iload   = bus.ramload;
            end
            default: ;
        endcase
    end

    assign bus.ramREN = ram_ren;
    assign bus.ramWEN = ram_wen;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DGRANT: begin
                if (dreq)          state_d = DGRANT;
                else if (bus.iREN) state_d = IGRANT;
                else               state_d = IDLE;
            end
            IGRANT: begin
                // dcache preempts after each completed icache word
                if (!bus.iREN)          state_d = dreq ? DGRANT : IDLE;
                else if (access && dreq) state_d = DGRANT;
                else                     state_d = IGRANT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE || access || state_d != state_q)
            cnt_d = '0;
        else if ((ram_ren | ram_wen) && cnt_q != CNT_W'(TIMEOUT))
            cnt_d = cnt_q + CNT_W'(1);

        err_d = err_q
              | ((state_q != IDLE) && (bus.ramstate == RAM_ERROR))
              | (cnt_d == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with TIMEOUT=4 and hand-computed expectations.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic err;
    int   checks = 0;
    int   errors = 0;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave),
        .err  (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = 32'hCAFE_F00D;
        bus.ramstate = FREE;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
        #1;
    endtask

    logic [31:0] exp_addr [1:10];
    logic [1:0]  t3_state [1:10];

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_ramREN", bus.ramREN, 0);
        check("rst_ramWEN", bus.ramWEN, 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_ramstore", bus.ramstore, 0);
        check("rst_iwait", bus.iwait, 1);
        check("rst_dwait", bus.dwait, 1);
        check("rst_iload", bus.iload, 0);
        check("rst_dload", bus.dload, 0);
        check("rst_err", err, 0);

        // ---------------- 1: dcache read, 2 BUSY then ACCESS ----------------
        bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY; #1;
        check("t1_c0_ramREN", bus.ramREN, 0);
        step();
        check("t1_c1_ramREN", bus.ramREN, 1);
        check("t1_c1_ramaddr", bus.ramaddr, 32'h100);
        check("t1_c1_dwait", bus.dwait, 1);
        step();
        check("t1_c2_dwait", bus.dwait, 1);
        step();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEAD_BEEF; #1;
        check("t1_c3_dwait", bus.dwait, 0);
        check("t1_c3_dload", bus.dload, 32'hDEAD_BEEF);
        check("t1_c3_iload", bus.iload, 0);
        step();
        bus.dREN = 0; bus.ramstate = FREE; #1;
        check("t1_c4_dwait", bus.dwait, 1);
        check("t1_c4_ramREN", bus.ramREN, 0);
        step();
        check("t1_idle_dload", bus.dload, 0);
        check("t1_idle_ramaddr", bus.ramaddr, 0);
        check("t1_err", err, 0);

        // ---------------- 2: iREN and dWEN together ----------------
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h40;
        bus.dWEN = 1; bus.dREN = 1; bus.daddr = 32'h500; bus.dstore = 32'h1234_5678;
        step();
        check("t2_ramWEN", bus.ramWEN, 1);
        check("t2_ramREN_wr_wins", bus.ramREN, 0);
        check("t2_ramstore", bus.ramstore, 32'h1234_5678);
        check("t2_ramaddr", bus.ramaddr, 32'h500);
        check("t2_iwait", bus.iwait, 1);
        bus.ramstate = ACCESS; #1;
        check("t2_dwait_acc", bus.dwait, 0);
        check("t2_iwait_acc", bus.iwait, 1);
        step();
        bus.ramstate = FREE; #1;
        check("t2_hold_ramWEN", bus.ramWEN, 1);
        check("t2_hold_iwait", bus.iwait, 1);
        step();
        bus.dWEN = 0; bus.dREN = 0; #1;
        check("t2_drop_ramWEN", bus.ramWEN, 0);
        check("t2_drop_iwait", bus.iwait, 1);
        step();
        check("t2_ig_ramaddr", bus.ramaddr, 32'h40);
        check("t2_ig_ramREN", bus.ramREN, 1);
        check("t2_ig_ramWEN", bus.ramWEN, 0);
        bus.ramstate = ACCESS; bus.ramload = 32'h0000_A5A5; #1;
        check("t2_ig_iwait", bus.iwait, 0);
        check("t2_ig_iload", bus.iload, 32'h0000_A5A5);
        check("t2_ig_dwait", bus.dwait, 1);

        // ---------------- 3: locked writeback + load sequence ----------------
        do_reset();
        exp_addr = '{32'h200, 32'h200, 32'h204, 32'h204, 32'h300,
                     32'h300, 32'h304, 32'h304, 32'h304, 32'h80};
        t3_state = '{BUSY, ACCESS, BUSY, ACCESS, BUSY, ACCESS, BUSY, ACCESS, FREE, FREE};
        bus.iREN = 1; bus.iaddr = 32'h80;
        bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h11;
        for (int c = 1; c <= 10; c++) begin
            step();
            case (c)
                3: begin bus.daddr = 32'h204; bus.dstore = 32'h22; end
                5: begin bus.dWEN = 0; bus.dREN = 1; bus.daddr = 32'h300; end
                7: bus.daddr = 32'h304;
                9: bus.dREN = 0;
                default: ;
            endcase
            bus.ramstate = t3_state[c];
            #1;
            check($sformatf("t3_c%0d_ramaddr", c), bus.ramaddr, exp_addr[c]);
            if (c <= 8)
                check($sformatf("t3_c%0d_dwait", c), bus.dwait, (t3_state[c] == ACCESS) ? 0 : 1);
        end
        check("t3_wr_en", 1'b0, 1'b0 & bus.ramWEN);

        // ---------------- 4: dcache preempts completing icache ----------------
        do_reset();
        bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        step();
        check("t4_c1_ramaddr", bus.ramaddr, 32'h40);
        check("t4_c1_ramREN", bus.ramREN, 1);
        step();
        bus.ramstate = ACCESS; bus.ramload = 32'h77; bus.dREN = 1; bus.daddr = 32'h600; #1;
        check("t4_c2_iwait", bus.iwait, 0);
        check("t4_c2_iload", bus.iload, 32'h77);
        check("t4_c2_dwait", bus.dwait, 1);
        step();
        bus.ramstate = BUSY; #1;
        check("t4_c3_ramaddr", bus.ramaddr, 32'h600);
        check("t4_c3_iwait", bus.iwait, 1);
        check("t4_c3_iload", bus.iload, 0);
        step();
        bus.ramstate = ACCESS; #1;
        check("t4_c4_dwait", bus.dwait, 0);
        step();
        bus.dREN = 0; bus.ramstate = FREE; #1;
        check("t4_c5_ramaddr", bus.ramaddr, 32'h600);
        check("t4_c5_iwait", bus.iwait, 1);
        step();
        check("t4_c6_ramaddr", bus.ramaddr, 32'h40);

        // ---------------- 5: timeout and ERROR ----------------
        do_reset();
        bus.dREN = 1; bus.daddr = 32'h700; bus.ramstate = BUSY;
        step();
        step(); step(); step();
        check("t5_err_after3", err, 0);
        step();
        check("t5_err_after4", err, 1);
        bus.ramstate = ACCESS;
        step();
        bus.dREN = 0; bus.ramstate = FREE;
        step(); step();
        check("t5_err_sticky_idle", err, 1);
        check("t5_idle_ramREN", bus.ramREN, 0);

        do_reset();
        check("t5b_err_rst", err, 0);
        bus.dREN = 1; bus.daddr = 32'h710;
        step();
        bus.ramstate = ERROR;
        step();
        bus.ramstate = ACCESS; #1;
        check("t5b_err_error", err, 1);
        check("t5b_dwait_acc", bus.dwait, 0);

        // ---------------- 6: async reset mid-DGRANT ----------------
        do_reset();
        bus.dWEN = 1; bus.daddr = 32'h800; bus.dstore = 32'h55;
        step();
        bus.ramstate = ERROR;
        step();
        bus.ramstate = BUSY; #1;
        check("t6_pre_ramWEN", bus.ramWEN, 1);
        check("t6_pre_err", err, 1);
        #1 nRST = 1'b0;
        #1;
        check("t6_async_ramWEN", bus.ramWEN, 0);
        check("t6_async_dwait", bus.dwait, 1);
        check("t6_async_err", err, 0);
        step();
        #2 nRST = 1'b1;
        #1;
        check("t6_rel_ramWEN", bus.ramWEN, 0);
        step();
        check("t6_regrant_ramWEN", bus.ramWEN, 1);
        check("t6_regrant_ramaddr", bus.ramaddr, 32'h800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
